tmds_encoder: RTL

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_encoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tmds_encoder.sv
// TMDS (DVI 1.0) 8b/10b channel encoder: 3-stage pipeline with signed running disparity.
// Define TMDS_ENCODER_OUTREG_EN to add one output register stage (latency 4 instead of 3).
module tmds_encoder #(
    parameter int unsigned DISP_W = 5
) (
    input  logic                     clk_pix,
    input  logic                     rst,
    input  logic                     de,
    input  logic [7:0]               data,
    input  logic [1:0]               ctrl,
    output logic [9:0]               tmds,
    output logic signed [DISP_W-1:0] disparity
);
    localparam int unsigned CNT_W   = 4;
    localparam logic [9:0]  CTRL_00 = 10'h354;
    localparam logic [9:0]  CTRL_01 = 10'h0AB;
    localparam logic [9:0]  CTRL_10 = 10'h154;
    localparam logic [9:0]  CTRL_11 = 10'h2AB;

    typedef logic signed [DISP_W-1:0] disp_t;

    logic             de1_q, de1_d;
    logic [1:0]       ctrl1_q, ctrl1_d;
    logic [7:0]       data1_q, data1_d;
    logic [CNT_W-1:0] n1d_q, n1d_d;

    logic             de2_q, de2_d;
    logic [1:0]       ctrl2_q, ctrl2_d;
    logic [8:0]       qm_q, qm_d;
    logic [CNT_W-1:0] n1q_q, n1q_d;
    logic [CNT_W-1:0] n0q_q, n0q_d;
    logic             use_xnor;

    logic [9:0]       tmds3_q, tmds3_d;
    disp_t            disp3_q, disp3_d;
    disp_t            diff_1m0, diff_0m1;
    logic             disp_pos, disp_neg;

    // S1: capture inputs and count ones of the pixel
    always_comb begin
        de1_d   = de;
        ctrl1_d = ctrl;
        data1_d = data;
        n1d_d   = '0;
        for (int i = 0; i < 8; i++) begin
            n1d_d = n1d_d + CNT_W'(data[i]);
        end
    end

    // S2: transition-minimising chain q_m and its ones/zeros balance
    always_comb begin
        de2_d    = de1_q;
        ctrl2_d  = ctrl1_q;
        use_xnor = (n1d_q > CNT_W'(4)) || ((n1d_q == CNT_W'(4)) && !data1_q[0]);
        qm_d     = '0;
        qm_d[0]  = data1_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data1_q[i]) : (qm_d[i-1] ^ data1_q[i]);
        end
        qm_d[8] = ~use_xnor;
        n1q_d   = '0;
        for (int i = 0; i < 8; i++) begin
            n1q_d = n1q_d + CNT_W'(qm_d[i]);
        end
        n0q_d = CNT_W'(8) - n1q_d;
    end

    // S3: DC-balancing inversion decision; sign tests use the pre-update disparity
    always_comb begin
        tmds3_d  = tmds3_q;
        disp3_d  = disp3_q;
        diff_1m0 = disp_t'(n1q_q) - disp_t'(n0q_q);
        diff_0m1 = disp_t'(n0q_q) - disp_t'(n1q_q);
        disp_neg = disp3_q[DISP_W-1];
        disp_pos = !disp_neg && (disp3_q != '0);
        if (!de2_q) begin
            case (ctrl2_q)
                2'b00:   tmds3_d = CTRL_00;
                2'b01:   tmds3_d = CTRL_01;
                2'b10:   tmds3_d = CTRL_10;
                default: tmds3_d = CTRL_11;
            endcase
            disp3_d = '0;
        end else if ((disp3_q == '0) || (n1q_q == n0q_q)) begin
            tmds3_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
            disp3_d = disp3_q + (qm_q[8] ? diff_1m0 : diff_0m1);
        end else if ((disp_pos && (n1q_q > n0q_q)) || (disp_neg && (n0q_q > n1q_q))) begin
            tmds3_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            disp3_d = disp3_q + (qm_q[8] ? disp_t'(2) : disp_t'(0)) + diff_0m1;
        end else begin
            tmds3_d = {1'b0, qm_q[8], qm_q[7:0]};
            disp3_d = disp3_q + diff_1m0 - (qm_q[8] ? disp_t'(0) : disp_t'(2));
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            de1_q   <= 1'b0;
            ctrl1_q <= 2'b00;
            data1_q <= '0;
            n1d_q   <= '0;
            de2_q   <= 1'b0;
            ctrl2_q <= 2'b00;
            qm_q    <= '0;
            n1q_q   <= '0;
            n0q_q   <= '0;
            tmds3_q <= CTRL_00;
            disp3_q <= '0;
        end else begin
            de1_q   <= de1_d;
            ctrl1_q <= ctrl1_d;
            data1_q <= data1_d;
            n1d_q   <= n1d_d;
            de2_q   <= de2_d;
            ctrl2_q <= ctrl2_d;
            qm_q    <= qm_d;
            n1q_q   <= n1q_d;
            n0q_q   <= n0q_d;
            tmds3_q <= tmds3_d;
            disp3_q <= disp3_d;
        end
    end

`ifdef TMDS_ENCODER_OUTREG_EN
    logic [9:0] tmds_o_q, tmds_o_d;
    disp_t      disp_o_q, disp_o_d;

    assign tmds_o_d = tmds3_q;
    assign disp_o_d = disp3_q;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            tmds_o_q <= CTRL_00;
            disp_o_q <= '0;
        end else begin
            tmds_o_q <= tmds_o_d;
            disp_o_q <= disp_o_d;
        end
    end

    assign tmds      = tmds_o_q;
    assign disparity = disp_o_q;
`else
    assign tmds      = tmds3_q;
    assign disparity = disp3_q;
`endif

endmodule
